// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-addressed synchronous data memory.
// Adds byte/halfword loads with extension, sub-word stores via read-modify-write and alignment checks.
module mem_access_unit #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_addrs,
    output logic [31:0] m_in,
    input  logic [31:0] m_out
);

    typedef enum logic [1:0] {StIdle, StRd, StCap, StWr} state_e;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        accept;
    logic        req_err;
    logic [1:0]  lane_b;
    logic        lane_h;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    assign accept = (state_q == StIdle) && req_valid;

    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            SizeByte: req_err = 1'b0;
            SizeHalf: req_err = req_addr[0];
            SizeWord: req_err = (req_addr[1:0] != 2'b00);
            default:  req_err = 1'b1;
        endcase
    end

    // Lane numbers below are in little-endian bit positions; big-endian mirrors the offset.
    always_comb begin
        lane_b   = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
        lane_h   = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];
        byte_val = m_out[{lane_b, 3'b000} +: 8];
        half_val = m_out[{lane_h, 4'b0000} +: 16];
    end

    always_comb begin
        load_val = m_out;
        unique case (size_q)
            SizeByte: load_val = {{24{~unsigned_q & byte_val[7]}}, byte_val};
            SizeHalf: load_val = {{16{~unsigned_q & half_val[15]}}, half_val};
            default:  load_val = m_out;
        endcase
    end

    always_comb begin
        merge_val = m_out;
        unique case (size_q)
            SizeByte: merge_val[{lane_b, 3'b000} +: 8] = wdata_q[7:0];
            SizeHalf: merge_val[{lane_h, 4'b0000} +: 16] = wdata_q[15:0];
            default:  merge_val = wdata_q;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && !req_err) begin
                    state_d = (req_we && req_size == SizeWord) ? StWr : StRd;
                end
            end
            StRd:  state_d = StCap;
            StCap: state_d = we_q ? StWr : StIdle;
            StWr:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: memory strobes decode from state and captured registers only
    always_comb begin
        busy    = (state_q != StIdle);
        m_read  = 1'b0;
        m_write = 1'b0;
        m_addrs = 32'h0;
        m_in    = 32'h0;
        unique case (state_q)
            StRd: begin
                m_read  = 1'b1;
                m_addrs = {addr_q[31:2], 2'b00};
            end
            StWr: begin
                m_write = 1'b1;
                m_addrs = {addr_q[31:2], 2'b00};
                m_in    = (size_q == SizeWord) ? wdata_q : merge_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        size_d       = size_q;
        we_d         = we_q;
        unsigned_d   = unsigned_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        if (accept) begin
            addr_d     = req_addr;
            size_d     = req_size;
            we_d       = req_we;
            unsigned_d = req_unsigned;
            wdata_d    = req_wdata;
            if (req_err) begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = 32'h0;
            end
        end
        if (state_q == StCap) begin
            if (we_q) begin
                merge_d = merge_val;
            end else begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_val;
            end
        end
        if (state_q == StWr) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= 32'h0;
            size_q       <= 2'b00;
            we_q         <= 1'b0;
            unsigned_q   <= 1'b0;
            wdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            addr_q       <= addr_d;
            size_q       <= size_d;
            we_q         <= we_d;
            unsigned_q   <= unsigned_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a little-endian and a big-endian instance share the
// request inputs, each with its own synchronous memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        init_mem = 1'b0;

    logic        busy0, resp_valid0, resp_err0, m_read0, m_write0;
    logic [31:0] resp_rdata0, m_addrs0, m_in0, m_out0;
    logic        busy1, resp_valid1, resp_err1, m_read1, m_write1;
    logic [31:0] resp_rdata1, m_addrs1, m_in1, m_out1;

    logic [31:0] mem0 [0:63];
    logic [31:0] mem1 [0:63];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy0), .resp_valid(resp_valid0), .resp_err(resp_err0), .resp_rdata(resp_rdata0),
        .m_read(m_read0), .m_write(m_write0), .m_addrs(m_addrs0), .m_in(m_in0), .m_out(m_out0)
    );

    mem_access_unit #(.BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy1), .resp_valid(resp_valid1), .resp_err(resp_err1), .resp_rdata(resp_rdata1),
        .m_read(m_read1), .m_write(m_write1), .m_addrs(m_addrs1), .m_in(m_in1), .m_out(m_out1)
    );

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) begin
                mem0[i] <= 32'h0;
                mem1[i] <= 32'h0;
            end
            mem0[4] <= 32'h8899AABB;
            mem1[0] <= 32'h11223344;
        end else begin
            if (m_write0) mem0[m_addrs0[7:2]] <= m_in0;
            if (m_write1) mem1[m_addrs1[7:2]] <= m_in1;
        end
        if (m_read0) m_out0 <= mem0[m_addrs0[7:2]];
        if (m_read1) m_out1 <= mem1[m_addrs1[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    // Request driven at negedge of cycle T; checks at the negedges of T+1..T+3.
    task automatic load_chk(input string tag, input bit be, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b0, size, uns, addr, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk_bit({tag, " m_read@T+1"}, m_read0, 1'b1);
        chk({tag, " m_addrs@T+1"}, m_addrs0, {addr[31:2], 2'b00});
        chk_bit({tag, " busy@T+1"}, busy0, 1'b1);
        @(negedge clk);
        chk_bit({tag, " m_read@T+2"}, m_read0, 1'b0);
        chk_bit({tag, " resp_valid@T+2"}, resp_valid0, 1'b0);
        @(negedge clk);
        chk_bit({tag, " resp_valid@T+3"}, resp_valid0, 1'b1);
        chk_bit({tag, " resp_err@T+3"}, resp_err0, 1'b0);
        chk_bit({tag, " busy@T+3"}, busy0, 1'b0);
        chk({tag, " rdata"}, be ? resp_rdata1 : resp_rdata0, exp);
    endtask

    task automatic rmw_chk(input string tag, input bit be, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_min);
        drive(1'b1, size, 1'b0, addr, wdata);
        @(negedge clk);
        req_valid = 1'b0;
        chk_bit({tag, " m_read@T+1"}, m_read0, 1'b1);
        chk_bit({tag, " m_write@T+1"}, m_write0, 1'b0);
        chk({tag, " m_addrs@T+1"}, m_addrs0, {addr[31:2], 2'b00});
        @(negedge clk);
        chk_bit({tag, " m_read@T+2"}, m_read0, 1'b0);
        chk_bit({tag, " m_write@T+2"}, m_write0, 1'b0);
        @(negedge clk);
        chk_bit({tag, " m_write@T+3"}, m_write0, 1'b1);
        chk_bit({tag, " m_read@T+3"}, m_read0, 1'b0);
        chk({tag, " m_in@T+3"}, be ? m_in1 : m_in0, exp_min);
        @(negedge clk);
        chk_bit({tag, " resp_valid@T+4"}, resp_valid0, 1'b1);
        chk_bit({tag, " resp_err@T+4"}, resp_err0, 1'b0);
        chk({tag, " rdata@T+4"}, resp_rdata0, 32'h0);
        chk_bit({tag, " m_write@T+4"}, m_write0, 1'b0);
    endtask

    task automatic err_chk(input string tag, input logic [1:0] size, input logic [31:0] addr);
        drive(1'b0, size, 1'b0, addr, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk_bit({tag, " resp_valid@T+1"}, resp_valid0, 1'b1);
        chk_bit({tag, " resp_err@T+1"}, resp_err0, 1'b1);
        chk({tag, " rdata@T+1"}, resp_rdata0, 32'h0);
        chk_bit({tag, " busy@T+1"}, busy0, 1'b0);
        chk_bit({tag, " m_read@T+1"}, m_read0, 1'b0);
        @(negedge clk);
        chk_bit({tag, " resp_valid@T+2"}, resp_valid0, 1'b0);
        chk_bit({tag, " resp_err@T+2"}, resp_err0, 1'b0);
        chk_bit({tag, " m_read@T+2"}, m_read0, 1'b0);
    endtask

    initial begin
        init_mem = 1'b1;
        @(negedge clk);
        @(negedge clk);
        init_mem = 1'b0;
        chk_bit("rst busy", busy0, 1'b0);
        chk_bit("rst resp_valid", resp_valid0, 1'b0);
        chk_bit("rst resp_err", resp_err0, 1'b0);
        chk_bit("rst m_read", m_read0, 1'b0);
        chk_bit("rst m_write", m_write0, 1'b0);
        chk("rst m_addrs", m_addrs0, 32'h0);
        chk("rst m_in", m_in0, 32'h0);
        chk("rst rdata", resp_rdata0, 32'h0);
        chk("rst rdata be", resp_rdata1, 32'h0);
        rst = 1'b0;

        // Little-endian loads of 0x8899AABB at 0x10, issued back to back
        load_chk("lb_s_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'hFFFFFF88);
        load_chk("lb_u_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h00000088);
        load_chk("lh_s_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'hFFFF8899);
        load_chk("lh_u_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h00008899);
        load_chk("lb_s_10", 1'b0, 2'b00, 1'b0, 32'h10, 32'hFFFFFFBB);
        load_chk("lb_u_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h000000AA);
        load_chk("lw_10", 1'b0, 2'b10, 1'b1, 32'h10, 32'h8899AABB);

        err_chk("err_lh_11", 2'b01, 32'h11);
        err_chk("err_lw_12", 2'b10, 32'h12);
        err_chk("err_size3", 2'b11, 32'h10);

        rmw_chk("sb_11", 1'b0, 2'b00, 32'h11, 32'h0000005A, 32'h88995ABB);
        load_chk("lw_after_sb", 1'b0, 2'b10, 1'b0, 32'h10, 32'h88995ABB);
        rmw_chk("sh_12", 1'b0, 2'b01, 32'h12, 32'hFFFF1234, 32'h12345ABB);
        load_chk("lw_after_sh", 1'b0, 2'b10, 1'b0, 32'h10, 32'h12345ABB);

        // Word store; a request while busy must be dropped
        drive(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        @(negedge clk);
        chk_bit("sw m_write@T+1", m_write0, 1'b1);
        chk_bit("sw m_read@T+1", m_read0, 1'b0);
        chk("sw m_in@T+1", m_in0, 32'hDEADBEEF);
        chk("sw m_addrs@T+1", m_addrs0, 32'h20);
        chk_bit("sw busy@T+1", busy0, 1'b1);
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk_bit("sw resp_valid@T+2", resp_valid0, 1'b1);
        chk_bit("sw resp_err@T+2", resp_err0, 1'b0);
        chk_bit("sw busy@T+2", busy0, 1'b0);
        chk_bit("sw m_write@T+2", m_write0, 1'b0);
        load_chk("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);

        // Reset while a byte store sits in CAP
        drive(1'b1, 2'b00, 1'b0, 32'h10, 32'h000000FF);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk_bit("rstmid busy in CAP", busy0, 1'b1);
        rst = 1'b1;
        #1;
        chk_bit("rstmid busy", busy0, 1'b0);
        chk_bit("rstmid m_read", m_read0, 1'b0);
        chk_bit("rstmid m_write", m_write0, 1'b0);
        chk("rstmid rdata", resp_rdata0, 32'h0);
        @(negedge clk);
        chk_bit("rstmid m_write+1", m_write0, 1'b0);
        chk_bit("rstmid resp_valid+1", resp_valid0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_bit("rstmid m_write+2", m_write0, 1'b0);
        chk_bit("rstmid resp_valid+2", resp_valid0, 1'b0);
        chk("rstmid mem", mem0[4], 32'h12345ABB);
        load_chk("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h12345ABB);

        // Big-endian instance, word 0x11223344 at 0x0
        load_chk("be_lw_0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344);
        load_chk("be_lbu_0", 1'b1, 2'b00, 1'b1, 32'h0, 32'h00000011);
        load_chk("be_lhu_2", 1'b1, 2'b01, 1'b1, 32'h2, 32'h00003344);
        load_chk("be_lb_3", 1'b1, 2'b00, 1'b0, 32'h3, 32'h00000044);
        load_chk("be_lh_0", 1'b1, 2'b01, 1'b0, 32'h0, 32'h00001122);
        rmw_chk("be_sb_1", 1'b1, 2'b00, 32'h1, 32'h000000AB, 32'h11AB3344);
        load_chk("be_lb_1", 1'b1, 2'b00, 1'b0, 32'h1, 32'hFFFFFFAB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator-side controller for the word-addressed synchronous data memory. It sits in the MEM stage between the pipeline and the data memory and drives m_read, m_write, m_addrs and m_in. It consumes m_out, which the memory returns one cycle after m_read. It adds byte and halfword loads with sign or zero extension, sub-word stores via read-modify-write, alignment checking and a busy/stall output.

Parameters:
BIG_ENDIAN, 0, byte-lane order. 0: byte offset k occupies bits [8k+7:8k]. 1: byte offset k occupies bits [31-8k:24-8k]. Halfwords follow the same rule on 16-bit pairs.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request strobe; accepted only when busy=0
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word; 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
busy  out  1  high whenever state != IDLE; pipeline stalls on it
resp_valid  out  1  single-cycle completion pulse, registered
resp_err  out  1  qualifies resp_valid; misaligned or illegal size
resp_rdata  out  32  load result, valid with resp_valid (0 for stores and errors)
m_read  out  1  memory read enable
m_write  out  1  memory write enable
m_addrs  out  32  word-aligned byte address {addr_q[31:2],2'b00}
m_in  out  32  memory write data
m_out  in  32  memory read data, valid the cycle after m_read

Behaviour:
- Reset (asynchronous): state=IDLE. busy, resp_valid, resp_err, m_read and m_write are 0. resp_rdata, m_addrs and m_in are 0. All captured request registers are cleared.
- m_read, m_write, m_addrs and m_in decode from state and registers only. Outside RD and WR they are all 0.
- Acceptance: the request is accepted when req_valid=1 in IDLE. addr, size, we, unsigned and wdata are captured on that edge. req_valid is ignored when busy=1.
- Error check at acceptance: size=11, halfword with addr[0]=1, or word with addr[1:0]!=0 is an error.
  - State stays IDLE.
  - Next cycle: resp_valid=1, resp_err=1, resp_rdata=0.
  - No memory access is made.
- States: IDLE, RD, CAP, WR.
- Load (accepted at cycle T):
  - IDLE->RD.
  - T+1 (RD): m_read=1. RD->CAP.
  - T+2 (CAP): m_out valid. Lane is extracted and extended, then registered. CAP->IDLE.
  - T+3: resp_valid=1, resp_rdata valid. Load latency is 3 cycles.
- Word store:
  - IDLE->WR.
  - T+1 (WR): m_write=1, m_in=wdata. WR->IDLE.
  - T+2: resp_valid=1.
- Sub-word store (read-modify-write):
  - IDLE->RD; T+1 m_read=1; RD->CAP.
  - T+2 (CAP): merge wdata[7:0] or wdata[15:0] into m_out at the selected lane and latch into the merge register. CAP->WR.
  - T+3 (WR): m_write=1, m_in=merge register. WR->IDLE.
  - T+4: resp_valid=1.
- Back-to-back: resp_valid coincides with IDLE, so a new request may be accepted in the same cycle resp_valid is high. Its own resp_valid follows no earlier than the next cycle.
- resp_valid and resp_err last exactly one cycle. resp_rdata holds until the next response.
- Extension:
  - Signed byte replicates bit 7 of the lane.
  - Signed halfword replicates bit 15 of the lane.
  - Unsigned fills with zeros.
  - Word ignores req_unsigned.
- Reset mid-operation: m_read and m_write drop immediately. No response is issued. An RMW abandoned before WR leaves memory unmodified.
- Single outstanding access only. The block never asserts m_read and m_write in the same cycle.

Test Plan:
- Preload mem word 0x10 = 0x8899AABB, BIG_ENDIAN=0. Signed byte load at 0x13 accepted at T -> m_read at T+1 with m_addrs=0x10; resp_valid at T+3 with resp_rdata=0xFFFFFF88. Unsigned byte load -> 0x00000088.
- Same word, halfword load at 0x12: signed -> 0xFFFF8899; unsigned -> 0x00008899. Halfword load at 0x11 -> resp_valid at T+1 with resp_err=1, m_read never asserted.
- Byte store 0x5A at 0x11 -> m_read at T+1, m_write at T+3 with m_in=0x8899 5ABB (0x88995ABB); resp_valid at T+4; a following word load at 0x10 returns 0x88995ABB.
- Word store 0xDEADBEEF at 0x20 -> m_write at T+1 with m_in=0xDEADBEEF; resp_valid at T+2; busy high only during T+1. A req_valid at T+1 is ignored; a new request at T+2 is accepted.
- Assert rst during CAP of a byte store -> m_read and m_write are 0 immediately, no resp_valid, memory word unchanged; after rst release a word load proceeds normally.
- BIG_ENDIAN=1, word 0x11223344 at 0x0: byte load at 0x0 -> 0x00000011 (unsigned); halfword load at 0x2 -> 0x00003344.
